prog_clk_divider: RTL
=====================

# prog_clk_divider

Multi-channel programmable clock divider, successor to the fixed divide-by-4 clk_divider (100 MHz to 25 MHz). It generates NUM_CH independent divided outputs from the single system clock, for example Morse dot-time ticks, display scan rate and tone frequency. Each channel provides both a 50%-duty square enable and a one-cycle tick. Divisors are runtime-programmable and change glitch-free at period boundaries.

## Interface
- NUM_CH, 2, number of divider channels (1..8)
- DIV_W, 16, divisor/counter width in bits
- DEFAULT_DIV, 4, divisor loaded into every channel on reset (4 reproduces the legacy 100 MHz to 25 MHz ratio)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global count enable; low freezes all counters and outputs
- sync_clr  in  1  synchronous clear of all channel counters (phase alignment)
- div_wr  in  1  one-cycle strobe: write div_data as the pending divisor of channel div_ch
- div_ch  in  $clog2(NUM_CH) (min 1)  channel select for div_wr
- div_data  in  DIV_W  new divisor N; 0 = channel stopped
- clk_out  out  NUM_CH  per-channel divided square output (registered)
- tick  out  NUM_CH  per-channel one-cycle pulse, once per period (registered)
- div_busy  out  NUM_CH  per channel: pending divisor not yet applied

## Operation
- Each channel holds the following:
  - active divisor A (reset to DEFAULT_DIV)
  - pending divisor P (reset to DEFAULT_DIV)
  - counter cnt (reset to 0)
  - pend flag (reset to 0)
- Counting, on each edge with en=1, sync_clr=0 and A≠0: cnt ← (cnt==A−1) ? 0 : cnt+1.
- Outputs, registered from the current cnt:
  - tick ← (cnt==A−1)
  - clk_out ← (cnt < A − floor(A/2))
  - Result: output period is A cycles, high for ceil(A/2) cycles and low for floor(A/2) cycles.
- A=1: tick high every enabled cycle; clk_out constant high.
- A=0: cnt held 0; tick and clk_out forced 0 on the next edge.
- en=0: cnt, tick and clk_out hold their values. div_wr is still accepted.
- sync_clr=1, taking priority over en: all cnt ← 0, all tick ← 0, all clk_out ← 0. Counting resumes from 0 on the next edge.
- Divisor write, on div_wr: P[div_ch] ← div_data and pend[div_ch] ← 1. If div_ch ≥ NUM_CH, the write is ignored.
- Divisor apply:
  - On an enabled edge where pend=1 and cnt==A−1 (wrap): A ← P, cnt ← 0, pend ← 0.
  - If A=0 (stopped), the apply happens on the next edge regardless of en.
  - No partial or truncated period is ever emitted.
- A second div_wr to the same channel before apply overwrites P (last write wins). pend stays 1.
- A div_wr coinciding with the wrap edge is captured into P but is applied at the following wrap. The wrap uses the old P.
- sync_clr does not clear pend.
- div_busy = pend.

## Timing
- Reset values: clk_out=0, tick=0, div_busy=0, all cnt=0.
- Reset is asynchronous. Asserting it mid-period immediately returns all state to reset values. The first count occurs on the first rising edge after deassertion.
- Output latency: tick and clk_out reflect cnt from the previous edge (one register stage).
- With A=N, tick is high on exactly one cycle out of every N enabled cycles.
- Apply latency: from div_wr to the new period start takes at most A_old + 1 cycles, given en held high.
- All arithmetic is unsigned DIV_W. A−1 is computed only when A≠0.

## Structure
- Package prog_clk_div_pkg holds:
  - DIV_W_DEFAULT
  - DEFAULT_DIV
  - the computed half-period function (A − A/2)
- Sub-module clk_div_chan, instanced NUM_CH times via generate, contains:
  - A, P, pend, cnt and output registers
  - inputs: en, sync_clr, a wr_sel strobe and div_data
- The top level contains only div_ch decode, generate loop and port concatenation.

## Test plan
- Reset, defaults (A=4), en=1 → each clk_out repeats 1,1,0,0 (period 4: 100 MHz → 25 MHz); tick is high on every 4th cycle; div_busy=0.
- Write div_data=5 to ch0 mid-period → div_busy[0]=1 until the current 4-cycle period ends, then ch0 clk_out shows high 3, low 2; ch1 is unaffected.
- Write 0 to ch1, then 3 after 10 cycles → ch1 outputs are 0 after the stop; the restart applies on the next edge, giving period 3 (high 2, low 1).
- Write 1 → tick high every cycle and clk_out constant 1; en=0 for 6 cycles → all outputs and counters freeze, then resume with correct phase.
- Two channels with different phases, pulse sync_clr → both clk_out=0 next cycle, then aligned ticks A−1 cycles later for equal divisors.
- Assert rst asynchronously mid-period with a pending write → outputs 0 immediately, A=P=DEFAULT_DIV, div_busy=0, the pending value is discarded.

Source files
------------

// File: rtl/prog_clk_divider_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package prog_clk_div_pkg;

    localparam int unsigned DIV_W_DEFAULT = 16;
    localparam int unsigned DEFAULT_DIV   = 4;

    // High portion of a period of length a: ceil(a/2) cycles.
    function automatic int unsigned high_len(input int unsigned a);
        return a - a / 2;
    endfunction

endpackage

// File: rtl/prog_clk_divider_chan.sv
// One divider channel: active/pending divisor, period counter and
// registered square/tick outputs with glitch-free divisor changeover.
module clk_div_chan
    import prog_clk_div_pkg::*;
#(
    parameter int unsigned DIV_W     = DIV_W_DEFAULT,
    parameter int unsigned RESET_DIV = DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr_sel,
    input  logic [DIV_W-1:0] div_data,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    logic [DIV_W-1:0] a;
    logic [DIV_W-1:0] p;
    logic [DIV_W-1:0] cnt;
    logic             pend;

    logic [DIV_W-1:0] a_m1;
    logic [DIV_W-1:0] hi_len;
    logic             stopped;
    logic             at_wrap;
    logic             apply;

    always_comb begin
        stopped = (a == '0);
        a_m1    = stopped ? '0 : a - DIV_W'(1);
        hi_len  = DIV_W'(high_len(32'(a)));
        at_wrap = !stopped && (cnt == a_m1);
        // A stopped channel has no period to finish, so it takes P at once.
        apply   = pend && (stopped || (en && !sync_clr && at_wrap));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= DIV_W'(RESET_DIV);
            p       <= DIV_W'(RESET_DIV);
            pend    <= 1'b0;
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            if (wr_sel) begin
                p <= div_data;
            end
            if (apply) begin
                a <= p;
            end
            // A write landing on the apply edge re-arms pend for the next wrap.
            if (wr_sel) begin
                pend <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end

            if (sync_clr || stopped) begin
                cnt     <= '0;
                tick    <= 1'b0;
                clk_out <= 1'b0;
            end else if (en) begin
                tick    <= at_wrap;
                clk_out <= (cnt < hi_len);
                cnt     <= at_wrap ? '0 : cnt + DIV_W'(1);
            end
        end
    end

    assign busy = pend;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: channel-select decode and one
// clk_div_chan per channel.
module prog_clk_divider #(
    parameter  int unsigned NUM_CH      = 2,
    parameter  int unsigned DIV_W       = prog_clk_div_pkg::DIV_W_DEFAULT,
    parameter  int unsigned DEFAULT_DIV = prog_clk_div_pkg::DEFAULT_DIV,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [DIV_W-1:0]  div_data,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_busy
);

    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range channel numbers match no channel, so the write is dropped.
    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = div_wr && (32'(div_ch) == i);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .DIV_W     (DIV_W),
            .RESET_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .sync_clr (sync_clr),
            .wr_sel   (wr_sel[i]),
            .div_data (div_data),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .busy     (div_busy[i])
        );
    end

endmodule
